// File: rtl/f1_reaction_timer.sv
// F1 start-light receiver: checks the 00->01->..->FF->00 build-up, times the driver's reaction
// from lights-out in ticks, and flags jump starts / illegal sequences. Optional macro: BEST_TIME_EN.
module f1_reaction_timer #(
    parameter int CNT_WIDTH = 12,
    parameter int TIMEOUT   = 2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           lights,
    input  logic                 tick,
    input  logic                 btn,
    output logic [CNT_WIDTH-1:0] react_time,
    output logic                 time_valid,
    output logic                 timeout,
    output logic                 jump_start,
    output logic                 seq_error,
    output logic [CNT_WIDTH-1:0] best_time
);

    typedef enum logic [2:0] {
        IDLE,
        ARMING,
        FULL,
        TIMING,
        CLEAR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TO_CNT = CNT_WIDTH'(TIMEOUT);

    state_t               state_q, state_d;
    logic [7:0]           lights_q;
    logic                 btn_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] react_q, react_d;
    logic                 tv_q, tv_d;
    logic                 to_q, to_d;
    logic                 js_q, js_d;
    logic                 se_q, se_d;
    logic                 btn_rise;
    logic                 grow;
    logic                 legal_step;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign btn_rise   = btn & ~btn_q;
    assign grow       = (lights == {lights_q[6:0], 1'b1});
    assign legal_step = (lights == lights_q) || grow || (lights_q == 8'hFF && lights == 8'h00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        react_d = react_q;
        tv_d    = 1'b0;
        to_d    = 1'b0;
        js_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lights_q == 8'h00 && lights == 8'h01) state_d = ARMING;
            end
            ARMING: begin
                // an illegal step outranks a simultaneous button edge
                if (!legal_step) begin
                    se_d    = 1'b1;
                    state_d = CLEAR;
                end else if (btn_rise) begin
                    js_d    = 1'b1;
                    state_d = CLEAR;
                end else if (lights == 8'hFF) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (lights == 8'h00) begin
                    cnt_d   = '0;
                    state_d = TIMING;
                end else if (lights != 8'hFF) begin
                    se_d    = 1'b1;
                    state_d = CLEAR;
                end else if (btn_rise) begin
                    js_d    = 1'b1;
                    state_d = CLEAR;
                end
            end
            TIMING: begin
                if (lights != 8'h00) begin
                    se_d    = 1'b1;
                    state_d = CLEAR;
                end else if (btn_rise) begin
                    react_d = cnt_q;
                    tv_d    = 1'b1;
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_d >= TO_CNT) begin
                        react_d = '1;
                        tv_d    = 1'b1;
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            CLEAR: begin
                if (lights == 8'h00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lights_q <= 8'h00;
            btn_q    <= 1'b0;
            cnt_q    <= '0;
            react_q  <= '0;
            tv_q     <= 1'b0;
            to_q     <= 1'b0;
            js_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            lights_q <= lights;
            btn_q    <= btn;
            cnt_q    <= cnt_d;
            react_q  <= react_d;
            tv_q     <= tv_d;
            to_q     <= to_d;
            js_q     <= js_d;
            se_q     <= se_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [CNT_WIDTH-1:0] best_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= '1;
        end else if (tv_d && !to_d && react_d < best_q) begin
            best_q <= react_d;
        end
    end

    assign best_time = best_q;
`else
    assign best_time = '1;
`endif

    assign react_time = react_q;
    assign time_valid = tv_q;
    assign timeout    = to_q;
    assign jump_start = js_q;
    assign seq_error  = se_q;

endmodule
